// File: rtl/ternary_popacc_pkg.sv
// Shared types, mode encodings and width helpers for the ternary popcount accumulator.
package ternary_popacc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic MODE_SIGNED = 1'b0;
    localparam logic MODE_POS    = 1'b1;

    // Bits needed to hold a popcount of 0..width.
    function automatic int pc_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Signed accumulator width covering -(width*beats) .. +(width*beats).
    function automatic int acc_width(input int width, input int beats);
        return $clog2(width * beats + 1) + 1;
    endfunction

    // Beat counter width; kept at least one bit so a single-beat build stays legal.
    function automatic int bc_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/ternary_popacc_seq_popcount_exact.sv
// Exact combinational popcount built as a balanced adder tree by recursive halving.
// Same shape as the approximate popcount cores (WIDTH in, PC_W out) so either can be dropped in.
module popcount_exact
    import ternary_popacc_pkg::*;
#(
    parameter  int WIDTH = 24,
    localparam int PC_W  = pc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [PC_W-1:0]  count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = vec;
        end else begin : g_node
            localparam int LO_W    = WIDTH / 2;
            localparam int HI_W    = WIDTH - LO_W;
            localparam int LO_PC_W = pc_width(LO_W);
            localparam int HI_PC_W = pc_width(HI_W);

            logic [LO_PC_W-1:0] lo_count_s;
            logic [HI_PC_W-1:0] hi_count_s;

            popcount_exact #(.WIDTH(LO_W)) u_lo (
                .vec   (vec[LO_W-1:0]),
                .count (lo_count_s)
            );

            popcount_exact #(.WIDTH(HI_W)) u_hi (
                .vec   (vec[WIDTH-1:LO_W]),
                .count (hi_count_s)
            );

            assign count = PC_W'(lo_count_s) + PC_W'(hi_count_s);
        end
    endgenerate

endmodule

// File: rtl/ternary_popacc_seq.sv
// Sequential ternary neuron: per-beat (pos - neg) popcounts accumulated over a frame
// of up to BEATS beats, compared against a per-frame threshold latched on the first beat.
module ternary_popacc_seq
    import ternary_popacc_pkg::*;
#(
    parameter  int WIDTH = 24,
    parameter  int BEATS = 4,
    parameter  int THR_W = 8,
    localparam int PC_W  = pc_width(WIDTH),
    localparam int ACC_W = acc_width(WIDTH, BEATS),
    localparam int BC_W  = bc_width(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_pos,
    input  logic [WIDTH-1:0]        in_neg,
    input  logic                    in_last,
    input  logic                    cfg_mode,
    input  logic signed [THR_W-1:0] cfg_thr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_fire,
    output logic                    out_trunc
);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [BC_W-1:0]         cnt_r;
    logic                    mode_r;
    logic signed [THR_W-1:0] thr_r;
    logic [PC_W-1:0]         pc_pos_r;
    logic [PC_W-1:0]         pc_neg_r;
    logic                    s1_valid_r;
    logic                    s1_last_r;
    logic                    trunc_r;
    logic signed [ACC_W-1:0] acc_r;

    logic                    accept_s;
    logic                    first_s;
    logic                    at_cap_s;
    logic                    last_s;
    logic                    trunc_s;
    logic                    mode_s;
    logic [WIDTH-1:0]        pos_eff_s;
    logic [WIDTH-1:0]        neg_eff_s;
    logic [PC_W-1:0]         pc_pos_s;
    logic [PC_W-1:0]         pc_neg_s;
    logic signed [ACC_W-1:0] diff_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [THR_W-1:0] sum_ext_s;

    assign accept_s = in_valid && (state_r == ACCUM);
    assign first_s  = (cnt_r == '0);
    assign at_cap_s = (cnt_r == BC_W'(BEATS - 1));
    assign last_s   = in_last || at_cap_s;
    assign trunc_s  = at_cap_s && !in_last;

    // The first beat of a frame is conditioned with the live mode; later beats use the latched one.
    always_comb begin
        mode_s    = mode_r;
        pos_eff_s = '0;
        neg_eff_s = '0;
        if (first_s) begin
            mode_s = cfg_mode;
        end else begin
            mode_s = mode_r;
        end
        if (mode_s == MODE_POS) begin
            pos_eff_s = in_pos;
            neg_eff_s = '0;
        end else begin
            pos_eff_s = in_pos & ~in_neg;
            neg_eff_s = in_neg & ~in_pos;
        end
    end

    popcount_exact #(.WIDTH(WIDTH)) u_pc_pos (
        .vec   (pos_eff_s),
        .count (pc_pos_s)
    );

    popcount_exact #(.WIDTH(WIDTH)) u_pc_neg (
        .vec   (neg_eff_s),
        .count (pc_neg_s)
    );

    // Stage-2 arithmetic: zero-extended popcounts subtracted in the signed accumulator width.
    always_comb begin
        diff_s    = $signed({{(ACC_W-PC_W){1'b0}}, pc_pos_r}) - $signed({{(ACC_W-PC_W){1'b0}}, pc_neg_r});
        sum_s     = acc_r + diff_s;
        sum_ext_s = THR_W'(sum_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a last beat sends us through one drain cycle into the result hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DRAIN: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // FSM outputs: beats are only taken while accumulating and never during reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n && (state_r == ACCUM)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Stage 1: capture popcounts, frame-end flags, beat count and first-beat configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            mode_r     <= MODE_SIGNED;
            thr_r      <= '0;
            pc_pos_r   <= '0;
            pc_neg_r   <= '0;
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            trunc_r    <= 1'b0;
        end else if (accept_s) begin
            pc_pos_r   <= pc_pos_s;
            pc_neg_r   <= pc_neg_s;
            s1_valid_r <= 1'b1;
            s1_last_r  <= last_s;
            trunc_r    <= trunc_s;
            if (last_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + BC_W'(1);
            end
            if (first_s) begin
                mode_r <= cfg_mode;
                thr_r  <= cfg_thr;
            end
        end else begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: accumulate, or on the frame's last beat publish the result and restart the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= '0;
            out_sum   <= '0;
            out_fire  <= 1'b0;
            out_trunc <= 1'b0;
            out_valid <= 1'b0;
        end else if (s1_valid_r && s1_last_r) begin
            out_sum   <= sum_s;
            out_fire  <= (sum_ext_s >= thr_r);
            out_trunc <= trunc_r;
            out_valid <= 1'b1;
            acc_r     <= '0;
        end else begin
            if (s1_valid_r) begin
                acc_r <= sum_s;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ternary_popacc_seq.md
Name: ternary_popacc_seq

Overview:
- Sequential, parametrised successor to the fixed 24-input combinational popcount cores.
- Evaluates one ternary neuron over a frame of 1..BEATS input beats, each WIDTH bits wide.
- Per beat: exact popcount of positive-weight hits minus popcount of negative-weight hits, accumulated into a signed sum, compared against a per-frame threshold.
- Sits between the on-sensor input serialiser and the activation/argmax stage; valid/ready on both sides.

Parameters:
- WIDTH, 24, bits per beat (popcount width).
- BEATS, 4, maximum beats per frame; beat BEATS is forced to be the frame's last beat.
- THR_W, 8, signed threshold width; must be >= ACC_W.
- Derived, not overridable: PC_W = clog2(WIDTH+1); ACC_W = clog2(WIDTH*BEATS+1)+1 (signed); BC_W = clog2(BEATS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- in_pos  in  WIDTH  bit i=1: input i contributes +1.
- in_neg  in  WIDTH  bit i=1: input i contributes -1.
- in_last  in  1  final beat of frame.
- cfg_mode  in  1  0 = signed (pos-neg), 1 = unsigned (pos only, in_neg ignored); sampled on a frame's first accepted beat.
- cfg_thr  in  THR_W  signed threshold; sampled on a frame's first accepted beat.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  result consumer ready.
- out_sum  out  ACC_W  signed accumulated sum.
- out_fire  out  1  out_sum >= latched threshold (signed compare).
- out_trunc  out  1  frame was closed by hitting BEATS without in_last.

Behaviour:
- Reset (async assert, sync release): state=ACCUM; stage-1 regs, accumulator, beat counter, latched cfg, out_* = 0; out_valid=0.
- in_ready: forced 0 while rst_n low; otherwise 1 only in ACCUM.
- Beat conditioning: bits with in_pos&in_neg both set count 0, giving pos_eff = in_pos&~in_neg and neg_eff = in_neg&~in_pos. In mode 1, pos_eff = in_pos and neg_eff = 0.
- Stage 1 (register): on accept, capture pc_pos = popcount(pos_eff) and pc_neg = popcount(neg_eff), each PC_W wide, plus a last flag.
  - The last flag is set by in_last, or by beat counter == BEATS-1; the latter also sets a trunc flag.
  - First beat of a frame (beat counter == 0) latches cfg_mode and cfg_thr.
- Stage 2: the cycle after a stage-1 capture, acc <= acc + (pc_pos - pc_neg), sign-extended to ACC_W. Overflow is impossible by sizing.
- FSM:
  - ACCUM: on accept with last → DRAIN; beat counter is cleared.
  - DRAIN: in_ready=0. At the next edge, stage 2 writes the final sum into out_sum, sets out_fire, out_trunc and out_valid=1, and clears acc → HOLD.
  - HOLD: out_* stable while out_valid & !out_ready. When out_ready=1, the handshake completes at that edge; out_valid=0 next cycle → ACCUM.
- Latency: out_valid rises 2 cycles after the last-beat accept edge (accept at edge E0, out_valid high after E1).
- Throughput: one frame of N beats per N+2 cycles with out_ready tied 1.
- Single-beat frame (in_last on first beat) is legal.
- A frame of all-zero beats gives out_sum=0; out_fire = (thr <= 0).
- Changes on cfg_* mid-frame are ignored.
- in_valid outside ACCUM is not accepted. The source must hold data until accepted.
- Reset mid-frame or mid-HOLD discards the partial sum and any pending result, with no output.

Decomposition:
- Package ternary_popacc_pkg holds:
  - state enum {ACCUM, DRAIN, HOLD};
  - mode constants MODE_SIGNED=0, MODE_POS=1;
  - width helper functions for PC_W/ACC_W/BC_W.
- Sub-module popcount_exact #(WIDTH): purely combinational adder-tree popcount, instantiated twice. It is the drop-in point for the evolved approximate popcount cores, so it keeps the same input/output shape (WIDTH in, PC_W out).

Test Plan:
- Defaults, mode 0, thr=0. Frame of 1 beat: in_pos=0x0000FF, in_neg=0x00000F, in_last=1 → 2 cycles later out_sum=4, out_fire=1, out_trunc=0.
- Frame of 4 beats, each in_pos=0, in_neg=0xFFFFFF, thr=-100 → out_sum=-96, out_fire=1; repeat with thr=-95 → out_fire=0.
- Overlap plus mode 1:
  - Mode 0, in_pos=in_neg=0xFFFFFF, 1 beat → out_sum=0.
  - Same data in mode 1 → out_sum=24.
  - cfg_mode toggled on beat 2 of a 3-beat frame has no effect.
- Truncation: 5 beats with in_last=0, in_pos=0x000001 → first result out_sum=4, out_trunc=1; beat 5 starts a new frame.
- Backpressure and reset:
  - out_ready=0 for 10 cycles → out_valid and out_sum stable, in_ready=0; out_ready=1 → next frame accepted the cycle after.
  - rst_n pulse during beat 2 of 3 → no result; next frame's sum excludes the pre-reset beats.
